// File: rtl/chose_2to1_arbiter_pkg.sv
// chose_arb_pkg: state and select encodings shared by the arbiter slice
package chose_arb_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;
    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;
    function automatic logic [1:0] own_state(input logic i);
        return i ? S_OWN1 : S_OWN0;
    endfunction
endpackage

// File: rtl/chose_2to1.sv
// chose_2to1: 1-bit 2-to-1 mux, s=0 picks a, s=1 picks b
module chose_2to1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

// File: rtl/chose_2to1_arbiter.sv
// chose_2to1_arbiter: 2-input round-robin burst arbiter with registered output; CHOSE_FIXED_PRIORITY_EN gives input 0 fixed priority
module chose_2to1_arbiter
    import chose_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);
    logic [1:0] state, nxt;
    logic [WIDTH-1:0] mux_y;
    logic space, xfer, own, own_req, oth_req;
    assign space = !out_valid || out_ready;
    assign ack0 = !rst && state == S_OWN0 && req0 && space;
    assign ack1 = !rst && state == S_OWN1 && req1 && space;
    assign xfer = ack0 || ack1;
    assign own = state == S_OWN1;
    assign own_req = own ? req1 : req0;
    assign oth_req = own ? req0 : req1;
    assign busy = state != S_IDLE;
    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        chose_2to1 u_mux (.a(data0[i]), .b(data1[i]), .s(sel), .y(mux_y[i]));
    end
`ifdef CHOSE_FIXED_PRIORITY_EN
    always_comb begin
        nxt = state;
        if (state == S_IDLE)
            nxt = req0 ? S_OWN0 : req1 ? S_OWN1 : S_IDLE;
        else if (!own_req || (own && xfer && req0))
            nxt = oth_req ? own_state(!own) : S_IDLE;
    end
`else
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    logic last, nxt_last, wrap;
    logic [CW-1:0] cnt, nxt_cnt;
    assign wrap = xfer && cnt == CNT_LAST;
    always_comb begin
        nxt = state;
        nxt_last = last;
        nxt_cnt = xfer ? (wrap ? '0 : cnt + CW'(1)) : cnt;
        if (state == S_IDLE) begin
            nxt = req0 && req1 ? own_state(!last) : req0 ? S_OWN0 : req1 ? S_OWN1 : S_IDLE;
            nxt_cnt = '0;
        end else if (!own_req || (wrap && oth_req)) begin
            nxt = oth_req ? own_state(!own) : S_IDLE;
            nxt_last = own;
            nxt_cnt = '0;
        end
    end
    // last=1 out of reset so input 0 wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
            cnt <= '0;
        end else begin
            last <= nxt_last;
            cnt <= nxt_cnt;
        end
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sel <= SEL_IN0;
            out_valid <= 1'b0;
            out_data <= '0;
        end else begin
            state <= nxt;
            sel <= nxt == S_OWN1 ? SEL_IN1 : SEL_IN0;
            out_valid <= xfer || (out_valid && !out_ready);
            if (xfer) out_data <= mux_y;
        end
    end
endmodule

// File: tb/tb_chose_2to1_arbiter.sv
// tb_chose_2to1_arbiter: scoreboard bench for chose_2to1_arbiter (MAX_BURST=4)
module tb_chose_2to1_arbiter;
    logic clk = 0, rst = 1, req0 = 0, req1 = 0, out_ready = 0;
    logic [7:0] data0 = 0, data1 = 0;
    logic ack0, ack1, out_valid, sel, busy;
    logic [7:0] out_data;
    logic [7:0] exp_q[$];
    int n_chk = 0, n_err = 0;

    chose_2to1_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_extra", 32'(out_data), 32'hdead_beef);
            else check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
        end

    task automatic drive(input logic r0, input logic [7:0] d0, input logic r1, input logic [7:0] d1,
                         input logic rdy, input logic e0, input logic e1, input logic es);
        @(posedge clk);
        #1;
        req0 = r0; data0 = d0; req1 = r1; data1 = d1; out_ready = rdy;
        if (e0 || e1) exp_q.push_back(e0 ? d0 : d1);
        @(negedge clk);
        check("ack0", 32'(ack0), 32'(e0));
        check("ack1", 32'(ack1), 32'(e1));
        check("sel", 32'(sel), 32'(es));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'({ack0, ack1}), 0);
        @(posedge clk);
        #1 rst = 0;
        // single requester: grant one cycle after req, data one cycle after ack
        drive(1, 8'ha5, 0, 0, 1, 0, 0, 0);
        check("s_busy0", 32'(busy), 0);
        drive(1, 8'ha5, 0, 0, 1, 1, 0, 0);
        check("s_busy1", 32'(busy), 1);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("s_valid", 32'(out_valid), 1);
        check("s_data", 32'(out_data), 32'h a5);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("s_idle", 32'({busy, out_valid}), 0);
        // reset while OWN1 holds unconsumed data
        drive(0, 0, 1, 8'h5a, 0, 0, 0, 0);
        drive(0, 0, 1, 8'h5a, 0, 0, 1, 1);
        drive(0, 0, 1, 8'h5a, 0, 0, 0, 1);
        check("r_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1 rst = 1; req0 = 1; out_ready = 1;
        @(negedge clk);
        check("r_ack", 32'({ack0, ack1}), 0);
        @(posedge clk);
        #1 rst = 0; req0 = 0; req1 = 0;
        exp_q.delete();
        @(negedge clk);
        check("r_busy", 32'(busy), 0);
        check("r_sel", 32'(sel), 0);
        check("r_valid0", 32'(out_valid), 0);
`ifdef CHOSE_FIXED_PRIORITY_EN
        for (int k = 0; k < 7; k++) drive(1, 8'h10, 1, 8'h20, 1, k >= 1, 0, 0);
        drive(0, 8'h10, 1, 8'h20, 1, 0, 0, 0);
        drive(1, 8'h10, 1, 8'h20, 1, 0, 1, 1);
        drive(1, 8'h10, 1, 8'h20, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("fp_drain", 32'(exp_q.size()), 0);
`else
        // contention: 4 from input 0, 4 from input 1, then back to 0
        for (int k = 0; k < 10; k++)
            drive(1, 8'h10, 1, 8'h20, 1, k >= 1 && (k <= 4 || k == 9), k >= 5 && k <= 8, k >= 5 && k <= 8);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("rr_drain", 32'(exp_q.size()), 0);
        // backpressure for 3 cycles, then owner 1 drops after 2 transfers
        drive(1, 8'h31, 0, 0, 1, 0, 0, 0);
        drive(1, 8'h31, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 8'h32, 1, 8'h41, 0, 0, 0, 0);
            check("bp_hold", 32'(out_data), 32'h31);
        end
        drive(1, 8'h32, 1, 8'h41, 1, 1, 0, 0);
        drive(1, 8'h33, 1, 8'h41, 1, 1, 0, 0);
        drive(1, 8'h34, 1, 8'h41, 1, 1, 0, 0);
        drive(1, 8'h35, 1, 8'h41, 1, 0, 1, 1);
        drive(1, 8'h35, 1, 8'h42, 1, 0, 1, 1);
        drive(1, 8'h35, 0, 8'h42, 1, 0, 0, 1);
        drive(1, 8'h35, 0, 8'h42, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("bp_drain", 32'(exp_q.size()), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
